nibble_packer: RTL

- Downstream consumer of the 8-stage, 4-bit shift delay line.
- Samples the delay-line output on every shift strobe and discards the priming samples while the line fills.
- Packs NIBBLES_PER_WORD nibbles into one word and buffers the words in a small FIFO.
- Presents the words to the next stage over a valid/ready handshake.

---
 rtl/nibble_packer_pkg.sv | 15 +
 rtl/nibble_packer_sync_word_fifo.sv | 75 +++++++
 rtl/nibble_packer.sv | 111 +++++++++++
 3 files changed

// File: rtl/nibble_packer_pkg.sv
// Shared constants for the nibble packer and the delay line that feeds it.
//   NIBBLE_W             width of one delay-line sample
//   DELAY_DEPTH          delay-line stages; also the number of priming strobes to discard
//   NIBBLES_PER_WORD_DEF default nibbles per packed word
//   FIFO_DEPTH_DEF       default output buffer depth (power of two, >= 2)
//   WORD_W               packed word width for the default configuration
package nibble_packer_pkg;

   localparam int unsigned NIBBLE_W             = 4;
   localparam int unsigned DELAY_DEPTH          = 8;
   localparam int unsigned NIBBLES_PER_WORD_DEF = 4;
   localparam int unsigned FIFO_DEPTH_DEF       = 4;
   localparam int unsigned WORD_W               = NIBBLE_W * NIBBLES_PER_WORD_DEF;

endpackage

// File: rtl/nibble_packer_sync_word_fifo.sv
// sync_word_fifo: single-clock word buffer with a separately tracked occupancy count.
//   clk        rising-edge clock
//   rst        synchronous active-low reset; empties the buffer
//   push       write push_data (ignored when full unless pop also happens)
//   push_data  word to write
//   pop        advance the head (ignored when empty)
//   head       word at the head, 0 when empty
//   count      occupancy, 0..Depth
//   full       count == Depth
//   empty      count == 0
module sync_word_fifo #(
   parameter int unsigned Width = 16,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [Width-1:0]           push_data,
   input  logic                       pop,
   output logic [Width-1:0]           head,
   output logic [$clog2(Depth+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   assign full  = (count_q == CntW'(Depth));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

   // A pop frees the slot in the same cycle, so a push into a full buffer succeeds then.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap naturally since Depth is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: head is masked while empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/nibble_packer.sv
// nibble_packer: discards the delay-line priming samples, packs nibbles low-first into
// words and buffers them for a valid/ready consumer.
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   shn         shift strobe shared with the delay line
//   nib_in      delay-line output
//   flush       drop the partial word and restart the fill count
//   word_out    FIFO head, 0 when empty
//   word_valid  FIFO not empty
//   word_ready  consumer takes word_out this cycle
//   count       FIFO occupancy
//   fill_done   priming complete, nibbles are being accepted
//   overflow    sticky: a completed word was dropped on a full FIFO
module nibble_packer
   import nibble_packer_pkg::*;
#(
   parameter int unsigned NIBBLES_PER_WORD = NIBBLES_PER_WORD_DEF,
   parameter int unsigned FILL_DEPTH       = DELAY_DEPTH,
   parameter int unsigned FIFO_DEPTH       = FIFO_DEPTH_DEF
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   shn,
   input  logic [NIBBLE_W-1:0]                    nib_in,
   input  logic                                   flush,
   output logic [NIBBLE_W*NIBBLES_PER_WORD-1:0]   word_out,
   output logic                                   word_valid,
   input  logic                                   word_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]        count,
   output logic                                   fill_done,
   output logic                                   overflow
);

   localparam int unsigned WordW = NIBBLE_W * NIBBLES_PER_WORD;
   localparam int unsigned FillW = $clog2(FILL_DEPTH + 1);
   localparam int unsigned IdxW  = (NIBBLES_PER_WORD > 1) ? $clog2(NIBBLES_PER_WORD) : 1;

   logic [FillW-1:0] fill_q, fill_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [WordW-1:0] acc_q, acc_d, acc_ins;
   logic             overflow_q, overflow_d;
   logic             accept, last, push, pop, fifo_full, fifo_empty;

   assign fill_done = (fill_q == FillW'(FILL_DEPTH));
   assign accept    = shn & fill_done & ~flush;
   assign last      = (idx_q == IdxW'(NIBBLES_PER_WORD - 1));
   assign push      = accept & last;
   assign pop       = word_ready & ~fifo_empty;

   // Accumulator with the incoming nibble dropped into its slot; on the last slot this
   // is the completed word handed to the FIFO.
   always_comb begin
      acc_ins = acc_q;
      acc_ins[NIBBLE_W*idx_q +: NIBBLE_W] = nib_in;
   end

   always_comb begin
      fill_d     = fill_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      overflow_d = overflow_q | (push & fifo_full & ~pop);
      if (flush) begin
         fill_d = '0;
         idx_d  = '0;
         acc_d  = '0;
      end else if (shn) begin
         if (!fill_done) begin
            fill_d = fill_q + FillW'(1);
         end else if (last) begin
            idx_d = '0;
            acc_d = '0;
         end else begin
            idx_d = idx_q + IdxW'(1);
            acc_d = acc_ins;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fill_q     <= '0;
         idx_q      <= '0;
         acc_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         fill_q     <= fill_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         overflow_q <= overflow_d;
      end
   end

   assign overflow   = overflow_q;
   assign word_valid = ~fifo_empty;

   sync_word_fifo #(
      .Width (WordW),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (acc_ins),
      .pop       (word_ready),
      .head      (word_out),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
